// File: rtl/alu_op_sequencer.sv
// Multi-cycle initiator: accepts one ALU instruction, reads the bank, captures the ALU result, writes back, retires.
// Optional ALU_SEQ_FLAGS_EN adds registered out_zero / out_neg result flags.
module alu_op_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    output logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [ADDR_W-1:0] out_rd
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              out_zero,
    output logic              out_neg
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              w_accept;
    logic              r_in_ready;
    logic              r_we;
    logic              r_out_valid;
    logic [OP_W-1:0]   r_op;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_result;

    assign w_accept = in_valid && r_in_ready && (r_state == S_IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake/strobe outputs are registered off the next state so none is combinational from inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_result    <= '0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == S_IDLE);
            r_we        <= (w_next_state == S_WB);
            r_out_valid <= (w_next_state == S_DONE);
            if (w_accept) begin
                r_op  <= in_op;
                r_rs1 <= in_rs1;
                r_rs2 <= in_rs2;
                r_rd  <= in_rd;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_zero <= (alu_result == '0);
            r_neg  <= alu_result[DATA_W-1];
        end
    end

    assign out_zero = r_zero;
    assign out_neg  = r_neg;
`endif

    assign in_ready     = r_in_ready;
    assign read_reg1    = r_rs1;
    assign read_reg2    = r_rs2;
    assign opcode       = r_op;
    assign write_reg    = r_rd;
    assign write_data   = r_result;
    assign write_enable = r_we;
    assign out_valid    = r_out_valid;
    assign out_result   = r_result;
    assign out_rd       = r_rd;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural register bank and ALU around it.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [3:0]  in_rd;
    logic [3:0]  read_reg1;
    logic [3:0]  read_reg2;
    logic [3:0]  opcode;
    logic [31:0] alu_result;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic        write_enable;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
`ifdef ALU_SEQ_FLAGS_EN
    logic        out_zero;
    logic        out_neg;
`endif

    logic [31:0] regs [16];
    logic        pl_en;
    logic [3:0]  pl_addr;
    logic [31:0] pl_data;
    int          we_count;
    int          n_cmp;
    int          n_mis;

    alu_op_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .opcode       (opcode),
        .alu_result   (alu_result),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .out_zero     (out_zero),
        .out_neg      (out_neg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank: preload port for the bench, otherwise written by the DUT strobe.
    always @(posedge clk) begin
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (write_enable) regs[write_reg] <= write_data;
    end

    always @(posedge clk) begin
        if (write_enable) we_count <= we_count + 1;
    end

    always_comb begin
        logic [31:0] a;
        logic [31:0] b;
        a = regs[read_reg1];
        b = regs[read_reg2];
        alu_result = '0;
        case (opcode)
            4'h0: alu_result = a + b;
            4'h1: alu_result = a - b;
            4'h2: alu_result = a & b;
            4'h3: alu_result = a | b;
            4'h4: alu_result = a ^ b;
            4'h5: alu_result = a << b[4:0];
            4'h6: alu_result = a >> b[4:0];
            4'h7: alu_result = $unsigned($signed(a) >>> b[4:0]);
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic offer(input logic [3:0] op, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [3:0] rd);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [3:0] rd, input logic [31:0] exp, input int stall);
        int we0;
        offer(op, rs1, rs2, rd);
        we0 = we_count;
        @(negedge clk);
        // Junk offer while busy must be ignored, not buffered.
        in_valid = 1'b1; in_op = 4'h3; in_rs1 = 4'hE; in_rs2 = 4'hD; in_rd = 4'hC;
        chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
        chk("exec_rs1", {28'd0, read_reg1}, {28'd0, rs1});
        chk("exec_rs2", {28'd0, read_reg2}, {28'd0, rs2});
        chk("exec_op", {28'd0, opcode}, {28'd0, op});
        chk("exec_we", {31'd0, write_enable}, 32'd0);
        @(negedge clk);
        chk("wb_we", {31'd0, write_enable}, 32'd1);
        chk("wb_reg", {28'd0, write_reg}, {28'd0, rd});
        chk("wb_data", write_data, exp);
        chk("wb_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("done_valid", {31'd0, out_valid}, 32'd1);
        chk("done_result", out_result, exp);
        chk("done_rd", {28'd0, out_rd}, {28'd0, rd});
        chk("done_we", {31'd0, write_enable}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("done_zero", {31'd0, out_zero}, {31'd0, exp == 32'd0});
        chk("done_neg", {31'd0, out_neg}, {31'd0, exp[31]});
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_result", out_result, exp);
            chk("stall_rd", {28'd0, out_rd}, {28'd0, rd});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("we_pulses", we_count - we0, 32'd1);
        chk("bank_rd", regs[rd], exp);
    endtask

    initial begin
        int we0;
        n_cmp = 0; n_mis = 0; we_count = 0;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_op = 4'h5; in_rs1 = 4'h1; in_rs2 = 4'h2; in_rd = 4'h3;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_buses", {read_reg1, read_reg2, opcode, write_reg, out_rd, 12'd0}, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_result", out_result, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        preload(4'd1, 32'd5);
        preload(4'd9, 32'd7);
        run_op(4'h0, 4'd1, 4'd9, 4'd3, 32'd12, 0);
        run_op(4'h0, 4'd1, 4'd3, 4'd2, 32'd17, 5);
        run_op(4'h0, 4'd2, 4'd9, 4'd2, 32'd24, 5);
        preload(4'd4, 32'd9);
        run_op(4'h1, 4'd4, 4'd4, 4'd4, 32'd0, 0);
        preload(4'd1, 32'h8000_0000);
        preload(4'd2, 32'd4);
        run_op(4'h7, 4'd1, 4'd2, 4'd5, 32'hF800_0000, 1);
        run_op(4'h6, 4'd1, 4'd2, 4'd11, 32'h0800_0000, 0);
        run_op(4'h5, 4'd9, 4'd2, 4'd10, 32'h0000_0070, 0);
        run_op(4'h3, 4'd1, 4'd2, 4'd0, 32'h8000_0004, 0);
        run_op(4'hF, 4'd1, 4'd2, 4'd7, 32'd0, 0);

        preload(4'd8, 32'h55);
        offer(4'h0, 4'd9, 4'd9, 4'd8);
        we0 = we_count;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_we", {31'd0, write_enable}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_buses", {read_reg1, read_reg2, opcode, out_rd, 16'd0}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_hold_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("midrst_no_write", we_count - we0, 32'd0);
        chk("midrst_bank", regs[8], 32'h55);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
        run_op(4'h4, 4'd3, 4'd9, 4'd6, 32'd11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
